// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one single-port memory between CPU (port 0) and DMA (port 1),
// with bounded bursts and one-cycle read return to the issuing port.
module mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter bit PRIO0     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    state_t     state;
    logic [3:0] count;
    logic       last_served;
    logic       xfer0, xfer1;

    assign xfer0     = state == GNT0 && req0;
    assign xfer1     = state == GNT1 && req1;
    assign gnt0      = state == GNT0;
    assign gnt1      = state == GNT1;
    assign owner     = state;
    assign mem_addr  = xfer0 ? addr0 : xfer1 ? addr1 : '0;
    assign mem_wdata = xfer0 ? wdata0 : xfer1 ? wdata1 : '0;
    assign mem_we    = (xfer0 && we0) || (xfer1 && we1);
    assign rdata0    = rvalid0 ? mem_rdata : '0;
    assign rdata1    = rvalid1 ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            last_served <= 1'b1;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
        end else begin
            rvalid0 <= xfer0 && !we0;
            rvalid1 <= xfer1 && !we1;
            if (xfer0) last_served <= 1'b0;
            if (xfer1) last_served <= 1'b1;
            case (state)
                IDLE: begin
                    count <= '0;
                    // last_served=1 means port 1 went last, so port 0 wins a tie
                    if (req0 && (!req1 || PRIO0 || last_served)) state <= GNT0;
                    else if (req1) state <= GNT1;
                end
                GNT0: begin
                    if (!req0) begin
                        count <= '0;
                        state <= req1 ? GNT1 : IDLE;
                    end else if (count == LAST) begin
                        count <= '0;
                        if (req1) state <= GNT1;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                GNT1: begin
                    if (!req1) begin
                        count <= '0;
                        state <= req0 ? GNT0 : IDLE;
                    end else if (count == LAST) begin
                        count <= '0;
                        if (req0) state <= GNT0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a fixed-priority and a round-robin arbiter with shared stimulus,
// each with its own memory, and checks them against a transfer-level reference model.
module tb_mem_arbiter;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

    logic       g0 [2], g1 [2], rv0 [2], rv1 [2], mwe [2];
    logic [7:0] rd0 [2], rd1 [2], maddr [2], mwd [2], mrd [2];
    logic [1:0] own [2];

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MB), .PRIO0(g == 0)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
            .gnt0(g0[g]), .rvalid0(rv0[g]), .rdata0(rd0[g]),
            .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
            .gnt1(g1[g]), .rvalid1(rv1[g]), .rdata1(rd1[g]),
            .mem_addr(maddr[g]), .mem_wdata(mwd[g]), .mem_we(mwe[g]),
            .mem_rdata(mrd[g]), .owner(own[g])
        );
    end

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a == 8'h10 ? 8'hA5 : a ^ 8'h5A;
    endfunction

    // memory behind each arbiter: synchronous read, data valid the cycle after the address
    logic [7:0] mem [2][256];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 256; a++) mem[i][a] <= init_val(8'(a));
            mem_ready <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) if (mwe[i]) mem[i][maddr[i]] <= mwd[i];
        end
        for (int i = 0; i < 2; i++) mrd[i] <= mem[i][maddr[i]];
    end

    // reference model: owner is -1 (none) or a port number; served counts transfers in this grant
    int         m_own [2], m_served [2], m_last [2];
    bit         m_rv0 [2], m_rv1 [2];
    logic [7:0] m_rd0 [2], m_rd1 [2];
    logic [7:0] mmem [2][256];
    bit         mmem_ready = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_own[i] <= -1; m_served[i] <= 0; m_last[i] <= 1;
                m_rv0[i] <= 1'b0; m_rv1[i] <= 1'b0;
            end
            if (!mmem_ready) begin
                for (int i = 0; i < 2; i++)
                    for (int a = 0; a < 256; a++) mmem[i][a] <= init_val(8'(a));
                mmem_ready <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int o = m_own[i];
                automatic bit mine = (o == 0) ? req0 : req1;
                automatic bit other = (o == 0) ? req1 : req0;
                automatic int t = (o >= 0 && mine) ? o : -1;
                m_rv0[i] <= t == 0 && !we0;
                m_rv1[i] <= t == 1 && !we1;
                m_rd0[i] <= mmem[i][addr0];
                m_rd1[i] <= mmem[i][addr1];
                if (t == 0 && we0) mmem[i][addr0] <= wdata0;
                if (t == 1 && we1) mmem[i][addr1] <= wdata1;
                if (t >= 0) m_last[i] <= t;
                if (o < 0) begin
                    m_served[i] <= 0;
                    m_own[i] <= (req0 && req1) ? ((i == 0 || m_last[i] == 1) ? 0 : 1)
                              : req0 ? 0 : req1 ? 1 : -1;
                end else if (!mine) begin
                    m_served[i] <= 0;
                    m_own[i] <= other ? 1 - o : -1;
                end else if (other && (m_served[i] + 1) % MB == 0) begin
                    m_served[i] <= 0;
                    m_own[i] <= 1 - o;
                end else begin
                    m_served[i] <= m_served[i] + 1;
                end
            end
        end
    end

    logic [38:0] e_vec [2], a_vec [2];
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            automatic bit x0 = m_own[i] == 0 && req0;
            automatic bit x1 = m_own[i] == 1 && req1;
            e_vec[i] = {m_own[i] == 0, m_own[i] == 1,
                        m_own[i] < 0 ? 2'b00 : m_own[i] == 0 ? 2'b01 : 2'b10,
                        (x0 && we0) || (x1 && we1),
                        x0 ? addr0 : x1 ? addr1 : 8'h00,
                        x0 ? wdata0 : x1 ? wdata1 : 8'h00,
                        m_rv0[i], m_rv1[i],
                        m_rv0[i] ? m_rd0[i] : 8'h00,
                        m_rv1[i] ? m_rd1[i] : 8'h00};
            a_vec[i] = {g0[i], g1[i], own[i], mwe[i], maddr[i], mwd[i], rv0[i], rv1[i], rd0[i], rd1[i]};
        end
    end

    task automatic tick(input bit r0, w0, input logic [7:0] a0, d0,
                        input bit r1, w1, input logic [7:0] a1, d1);
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #3;
    endtask

    task automatic idle();
        tick(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        repeat (3) idle();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({g0[i], g1[i], own[i], rv0[i], rv1[i]} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_hold inst%0d: got %b want 000000", i, {g0[i], g1[i], own[i], rv0[i], rv1[i]});
            end
        end
        rst_n = 1'b1;
        repeat (5) begin
            idle();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({g0[i], g1[i], own[i], mwe[i], maddr[i]} !== 13'b0) begin
                    n_bad++;
                    $display("FAIL reset_idle inst%0d: got %h want 0", i, {g0[i], g1[i], own[i], mwe[i], maddr[i]});
                end
            end
        end
    endtask

    task automatic test_single_read();
        tick(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        n_cmp++;
        if (g0[0] !== 1'b0) begin n_bad++; $display("FAIL read_latency: gnt0 got %b want 0", g0[0]); end
        tick(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({g0[i], own[i], maddr[i], mwe[i]} !== {1'b1, 2'b01, 8'h10, 1'b0}) begin
                n_bad++;
                $display("FAIL read_grant inst%0d: got %h want %h", i, {g0[i], own[i], maddr[i], mwe[i]}, {1'b1, 2'b01, 8'h10, 1'b0});
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rv0[i], rd0[i], rv1[i], maddr[i]} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
                n_bad++;
                $display("FAIL read_data inst%0d: got %h want %h", i, {rv0[i], rd0[i], rv1[i], maddr[i]}, {1'b1, 8'hA5, 1'b0, 8'h00});
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({g0[i], rv0[i], own[i]} !== 4'b0) begin
                n_bad++;
                $display("FAIL read_release inst%0d: got %b want 0000", i, {g0[i], rv0[i], own[i]});
            end
        end
    endtask

    task automatic test_write_readback();
        tick(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
        tick(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({g1[i], mwe[i], maddr[i], mwd[i]} !== {1'b1, 1'b1, 8'h20, 8'h3C}) begin
                n_bad++;
                $display("FAIL write_issue inst%0d: got %h want %h", i, {g1[i], mwe[i], maddr[i], mwd[i]}, {1'b1, 1'b1, 8'h20, 8'h3C});
            end
        end
        tick(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({mwe[i], rv1[i], maddr[i]} !== {1'b0, 1'b0, 8'h20}) begin
                n_bad++;
                $display("FAIL write_no_rvalid inst%0d: got %h want %h", i, {mwe[i], rv1[i], maddr[i]}, {1'b0, 1'b0, 8'h20});
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rv1[i], rd1[i], rv0[i]} !== {1'b1, 8'h3C, 1'b0}) begin
                n_bad++;
                $display("FAIL write_readback inst%0d: got %h want %h", i, {rv1[i], rd1[i], rv0[i]}, {1'b1, 8'h3C, 1'b0});
            end
        end
        idle();
    endtask

    task automatic test_contention();
        tick(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00);
        for (int k = 0; k < 16; k++) begin
            tick(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00);
            for (int i = 0; i < 2; i++) begin
                automatic logic [1:0] want = ((k / MB) % 2 == 0) ? 2'b01 : 2'b10;
                n_cmp++;
                if (own[i] !== want) begin
                    n_bad++;
                    $display("FAIL contention inst%0d cyc%0d: owner got %b want %b", i, k, own[i], want);
                end
            end
        end
        idle();
        idle();
        idle();
    endtask

    task automatic test_round_robin();
        tick(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00);
        tick(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        idle();
        tick(1, 0, 8'h51, 8'h00, 1, 0, 8'h52, 8'h00);
        tick(1, 0, 8'h51, 8'h00, 1, 0, 8'h52, 8'h00);
        n_cmp++;
        if ({g1[1], own[1]} !== 3'b110) begin n_bad++; $display("FAIL rr_first: got %b want 110", {g1[1], own[1]}); end
        n_cmp++;
        if ({g0[0], own[0]} !== 3'b101) begin n_bad++; $display("FAIL prio_first: got %b want 101", {g0[0], own[0]}); end
        idle();
        idle();
        tick(1, 0, 8'h53, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, 8'h53, 8'h00, 0, 0, 8'h00, 8'h00);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({g0[i], own[i]} !== 3'b101) begin
                    n_bad++;
                    $display("FAIL solo_hold inst%0d cyc%0d: got %b want 101", i, k, {g0[i], own[i]});
                end
            end
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00);
        n_cmp++;
        if ({g1[1], rv1[1]} !== 2'b11) begin n_bad++; $display("FAIL mid_pre: got %b want 11", {g1[1], rv1[1]}); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({g1[1], rv1[1], own[1]} !== 4'b0) begin
            n_bad++;
            $display("FAIL mid_async: got %b want 0000", {g1[1], rv1[1], own[1]});
        end
        idle();
        rst_n = 1'b1;
        repeat (2) begin
            idle();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({rv0[i], rv1[i]} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL mid_stale inst%0d: got %b want 00", i, {rv0[i], rv1[i]});
                end
            end
        end
        tick(1, 0, 8'h61, 8'h00, 1, 0, 8'h62, 8'h00);
        tick(1, 0, 8'h61, 8'h00, 1, 0, 8'h62, 8'h00);
        n_cmp++;
        if ({g0[1], own[1]} !== 3'b101) begin n_bad++; $display("FAIL mid_rr_after: got %b want 101", {g0[1], own[1]}); end
        idle();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            // a waiting requester keeps its request stable until both arbiters have granted it
            if (!req0 || (m_own[0] == 0 && m_own[1] == 0)) begin
                req0 = $urandom_range(0, 3) != 0; we0 = $urandom_range(0, 2) == 0;
                addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
            end
            if (!req1 || (m_own[0] == 1 && m_own[1] == 1)) begin
                req1 = $urandom_range(0, 3) != 0; we1 = $urandom_range(0, 2) == 0;
                addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
            end
            #3;
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (a_vec[i] !== e_vec[i]) begin
                    n_bad++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h", i, n, a_vec[i], e_vec[i]);
                end
            end
        end
        idle();
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
